// File: rtl/tmds_pkg.sv
// Shared constants, FSM state type and token helper for the TMDS receive decoder.
// Optional error counter in the top is enabled with TMDS_DEC_ERR_CNT_EN.
package tmds_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] TMDS_TOK_C00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] TMDS_TOK_C01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] TMDS_TOK_C10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] TMDS_TOK_C11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } tmds_dec_state_t;

   function automatic logic tmds_is_tok(input logic [SYM_W-1:0] w);
      return (w == TMDS_TOK_C00) || (w == TMDS_TOK_C01) ||
             (w == TMDS_TOK_C10) || (w == TMDS_TOK_C11);
   endfunction

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into control or pixel data.
module tmds_sym_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] q,
   output logic             is_ctl,
   output logic [1:0]       ctl,
   output logic [7:0]       d
);

   logic [7:0] m_s;

   // Token lookup, then undo the optional inversion and the xor/xnor chain.
   always_comb begin
      is_ctl = 1'b1;
      ctl    = 2'b00;
      case (q)
         TMDS_TOK_C00: ctl = 2'b00;
         TMDS_TOK_C01: ctl = 2'b01;
         TMDS_TOK_C10: ctl = 2'b10;
         TMDS_TOK_C11: ctl = 2'b11;
         default: begin
            is_ctl = 1'b0;
            ctl    = 2'b00;
         end
      endcase

      m_s  = q[9] ? ~q[7:0] : q[7:0];
      d    = 8'h00;
      d[0] = m_s[0];
      for (int i = 1; i < 8; i++) begin
         if (q[8]) begin
            d[i] = m_s[i] ^ m_s[i-1];
         end else begin
            d[i] = ~(m_s[i] ^ m_s[i-1]);
         end
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: word alignment from control-token runs, then symbol decode.
// Define TMDS_DEC_ERR_CNT_EN to add the saturating err_cnt alignment-error counter.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_COUNT = 8,
   parameter int MISS_LIMIT = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] sym_in,
   output logic [7:0]       data,
   output logic [1:0]       c,
   output logic             de,
   output logic             locked,
   output logic [3:0]       offset
`ifdef TMDS_DEC_ERR_CNT_EN
   ,
   output logic [15:0]      err_cnt
`endif
);

   logic [SYM_W-1:0]   prev_r;
   logic [2*SYM_W-1:0] hist_s;
   logic [SYM_W-1:0]   tok_hit_s;
   logic               tok_any_s;
   logic [3:0]         tok_k_s;
   logic               tok_at_cand_s;
   logic               tok_at_off_s;
   logic               miss_s;

   tmds_dec_state_t    state_r, state_nxt_s;
   logic [3:0]         cand_r, cand_nxt_s;
   logic [3:0]         offset_nxt_s;
   logic [7:0]         run_r, run_nxt_s;
   logic [7:0]         miss_r, miss_nxt_s;

   logic [SYM_W-1:0]   q_sel_s;
   logic [SYM_W-1:0]   q_r;
   logic               vld_r;
   logic               dec_is_ctl_s;
   logic [1:0]         dec_ctl_s;
   logic [7:0]         dec_d_s;

   assign hist_s = {sym_in, prev_r};

   for (genvar k = 0; k < SYM_W; k++) begin : g_scan
      assign tok_hit_s[k] = tmds_is_tok(hist_s[k +: SYM_W]);
   end

   assign tok_any_s     = |tok_hit_s;
   assign tok_at_cand_s = tok_hit_s[cand_r];
   assign tok_at_off_s  = tok_hit_s[offset];

   // Lowest matching offset wins: scan downwards so the last hit kept is the smallest.
   always_comb begin
      tok_k_s = 4'd0;
      for (int k = SYM_W - 1; k >= 0; k--) begin
         if (tok_hit_s[k]) begin
            tok_k_s = 4'(k);
         end else begin
            tok_k_s = tok_k_s;
         end
      end
   end

   // Alignment FSM next-state logic.
   always_comb begin
      state_nxt_s  = state_r;
      cand_nxt_s   = cand_r;
      run_nxt_s    = run_r;
      miss_nxt_s   = miss_r;
      offset_nxt_s = offset;
      miss_s       = 1'b0;
      case (state_r)
         SEARCH: begin
            if (tok_any_s) begin
               cand_nxt_s  = tok_k_s;
               run_nxt_s   = 8'd1;
               state_nxt_s = CHECK;
            end else begin
               run_nxt_s   = 8'd0;
            end
         end
         CHECK: begin
            if (tok_at_cand_s) begin
               if (run_r == 8'(LOCK_COUNT - 1)) begin
                  state_nxt_s  = LOCKED;
                  offset_nxt_s = cand_r;
                  run_nxt_s    = 8'd0;
                  miss_nxt_s   = 8'd0;
               end else begin
                  run_nxt_s    = run_r + 8'd1;
               end
            end else if (tok_any_s) begin
               cand_nxt_s  = tok_k_s;
               run_nxt_s   = 8'd1;
            end else begin
               state_nxt_s = SEARCH;
               run_nxt_s   = 8'd0;
            end
         end
         LOCKED: begin
            miss_s = tok_any_s && !tok_at_off_s;
            if (miss_s) begin
               if (miss_r == 8'(MISS_LIMIT - 1)) begin
                  state_nxt_s = SEARCH;
                  miss_nxt_s  = 8'd0;
               end else begin
                  miss_nxt_s  = miss_r + 8'd1;
               end
            end else begin
               miss_nxt_s = 8'd0;
            end
         end
         default: begin
            state_nxt_s = SEARCH;
            run_nxt_s   = 8'd0;
            miss_nxt_s  = 8'd0;
         end
      endcase
   end

   assign q_sel_s = hist_s[{1'b0, offset_nxt_s} +: SYM_W];

   // Stage 1: history, alignment state, and the word captured for decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r  <= '0;
         state_r <= SEARCH;
         cand_r  <= 4'd0;
         run_r   <= 8'd0;
         miss_r  <= 8'd0;
         offset  <= 4'd0;
         q_r     <= '0;
         vld_r   <= 1'b0;
      end else begin
         prev_r  <= sym_in;
         state_r <= state_nxt_s;
         cand_r  <= cand_nxt_s;
         run_r   <= run_nxt_s;
         miss_r  <= miss_nxt_s;
         offset  <= offset_nxt_s;
         q_r     <= q_sel_s;
         vld_r   <= (state_nxt_s == LOCKED);
      end
   end

   tmds_sym_decode u_dec (
      .q      (q_r),
      .is_ctl (dec_is_ctl_s),
      .ctl    (dec_ctl_s),
      .d      (dec_d_s)
   );

   // Stage 2: registered outputs; c and data hold whenever they are not refreshed.
   always_ff @(posedge clk) begin
      if (rst) begin
         data   <= 8'h00;
         c      <= 2'b00;
         de     <= 1'b0;
         locked <= 1'b0;
      end else begin
         locked <= vld_r;
         if (vld_r) begin
            if (dec_is_ctl_s) begin
               de <= 1'b0;
               c  <= dec_ctl_s;
            end else begin
               de   <= 1'b1;
               data <= dec_d_s;
            end
         end else begin
            de <= 1'b0;
         end
      end
   end

`ifdef TMDS_DEC_ERR_CNT_EN
   logic        drop_s;
   logic [16:0] err_sum_s;

   assign drop_s    = (state_r == LOCKED) && (state_nxt_s == SEARCH);
   assign err_sum_s = {1'b0, err_cnt} + {16'd0, miss_s} + {16'd0, drop_s};

   // Saturating count of locked misses and lock drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= 16'h0000;
      end else begin
         err_cnt <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a bit-serial transmit queue feeds the DUT,
// a reference model predicts every output cycle and a monitor compares them.
module tb_tmds_decoder;

   localparam int LOCK_COUNT = 8;
   localparam int MISS_LIMIT = 4;
   localparam logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

   typedef struct packed {
      logic        lk;
      logic        de;
      logic [1:0]  c;
      logic [7:0]  data;
      logic [3:0]  off;
      logic [15:0] err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sym_in = 10'd0;
   logic [7:0]  data;
   logic [1:0]  c;
   logic        de;
   logic        locked;
   logic [3:0]  offset;
`ifdef TMDS_DEC_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   txq[$];
   bit [7:0] byte_of [bit [9:0]];
   int   enc_cnt = 0;

   // reference model state
   bit       win [20];
   bit [9:0] m_prev;
   int       ms, mcand, mrun, mmiss, moff, m_err;
   bit       pv;
   bit [9:0] pw;
   bit       o_lk, o_de;
   bit [1:0] o_c;
   bit [7:0] o_data;

   always #5 clk = ~clk;

   tmds_decoder dut (
      .clk     (clk),
      .rst     (rst),
      .sym_in  (sym_in),
      .data    (data),
      .c       (c),
      .de      (de),
      .locked  (locked),
      .offset  (offset)
`ifdef TMDS_DEC_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   // DVI transmit encoder with running disparity; records symbol -> byte.
   function automatic bit [9:0] tmds_encode(input bit [7:0] d);
      bit [8:0] qm;
      bit [9:0] q;
      bit       use_xnor;
      int       n1d, n1q, n0q;
      n1d      = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && !d[0]);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
      end
      byte_of[q] = d;
      return q;
   endfunction

   function automatic int tok_index(input bit [9:0] w);
      for (int t = 0; t < 4; t++) if (w == TOKS[t]) return t;
      return -1;
   endfunction

   function automatic bit [9:0] word_at(input int k);
      bit [9:0] w;
      for (int j = 0; j < 10; j++) w[j] = win[k + j];
      return w;
   endfunction

   function automatic bit [7:0] ref_decode(input bit [9:0] w);
      bit [7:0] m, x;
      if (byte_of.exists(w)) return byte_of[w];
      m = w[9] ? ~w[7:0] : w[7:0];
      x = m ^ (m << 1);
      if (!w[8]) x = x ^ 8'hFE;
      return x;
   endfunction

   function automatic void model_step(input bit [9:0] s, input bit r);
      bit hit [10];
      int lo, t;
      if (r) begin
         ms = 0; mcand = 0; mrun = 0; mmiss = 0; moff = 0; m_err = 0;
         pv = 1'b0; pw = '0; m_prev = '0;
         o_lk = 1'b0; o_de = 1'b0; o_c = 2'b00; o_data = 8'h00;
         return;
      end
      for (int j = 0; j < 10; j++) begin
         win[j]      = m_prev[j];
         win[j + 10] = s[j];
      end
      lo = -1;
      for (int k = 0; k < 10; k++) begin
         hit[k] = (tok_index(word_at(k)) >= 0);
         if (hit[k] && lo < 0) lo = k;
      end
      o_lk = pv;
      if (pv) begin
         t = tok_index(pw);
         if (t >= 0) begin
            o_de = 1'b0;
            o_c  = 2'(t);
         end else begin
            o_de   = 1'b1;
            o_data = ref_decode(pw);
         end
      end else begin
         o_de = 1'b0;
      end
      if (ms == 0) begin
         if (lo >= 0) begin mcand = lo; mrun = 1; ms = 1; end
      end else if (ms == 1) begin
         if (hit[mcand]) begin
            mrun++;
            if (mrun == LOCK_COUNT) begin ms = 2; moff = mcand; mmiss = 0; end
         end else if (lo >= 0) begin
            mcand = lo; mrun = 1;
         end else begin
            ms = 0; mrun = 0;
         end
      end else begin
         if (lo >= 0 && !hit[moff]) begin
            mmiss++;
            m_err++;
            if (mmiss == MISS_LIMIT) begin ms = 0; mmiss = 0; m_err++; end
         end else begin
            mmiss = 0;
         end
      end
      if (m_err > 65535) m_err = 65535;
      pv     = (ms == 2);
      pw     = word_at(moff);
      m_prev = s;
   endfunction

   task automatic step(input logic [9:0] w, input logic r);
      exp_t e;
      sym_in = w;
      rst    = r;
      model_step(w, r);
      @(posedge clk);
      e.lk = o_lk; e.de = o_de; e.c = o_c; e.data = o_data;
      e.off = 4'(moff); e.err = 16'(m_err);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic enqueue(input bit [9:0] w);
      for (int j = 0; j < 10; j++) txq.push_back(w[j]);
   endtask

   function automatic bit [9:0] pull();
      bit [9:0] w;
      for (int j = 0; j < 10; j++) w[j] = txq.pop_front();
      return w;
   endfunction

   task automatic drain();
      while (txq.size() >= 10) step(pull(), 1'b0);
   endtask

   task automatic do_reset(input int n);
      repeat (n) step(10'd0, 1'b1);
      txq.delete();
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // Monitor: one expected record per clock edge, compared on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         if ({locked, de, c, data, offset} !== {mon_e.lk, mon_e.de, mon_e.c, mon_e.data, mon_e.off}) begin
            n_bad++;
            $display("FAIL out @%0t: got lk=%0b de=%0b c=%0h data=%0h off=%0d, want lk=%0b de=%0b c=%0h data=%0h off=%0d",
                     $time, locked, de, c, data, offset, mon_e.lk, mon_e.de, mon_e.c, mon_e.data, mon_e.off);
         end
`ifdef TMDS_DEC_ERR_CNT_EN
         n_cmp++;
         if (err_cnt !== mon_e.err) begin
            n_bad++;
            $display("FAIL err_cnt @%0t: got %0d, want %0d", $time, err_cnt, mon_e.err);
         end
`endif
      end
   end

   logic [7:0] seen[$];
   logic [7:0] want_bytes [3] = '{8'hFF, 8'h00, 8'hAB};
   bit         saw_drop;

   initial begin
      // reset and idle
      do_reset(4);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_de", 32'(de), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_c", 32'(c), 32'd0);
      check("rst_offset", 32'(offset), 32'd0);

      // lock at offset 0: locked rises 9 edges after the first token edge
      repeat (12) enqueue(TOKS[0]);
      for (int i = 1; i <= 12; i++) begin
         step(pull(), 1'b0);
         if (i == 9) check("lock_early", 32'(locked), 32'd0);
         if (i == 10) begin
            check("lock_at_9", 32'(locked), 32'd1);
            check("lock_off0", 32'(offset), 32'd0);
            check("lock_c00", 32'(c), 32'd0);
            check("lock_de0", 32'(de), 32'd0);
         end
      end

      // slipped stream: tokens begin 7 bits into each word
      do_reset(2);
      repeat (7) txq.push_back(1'b0);
      repeat (20) enqueue(TOKS[1]);
      drain();
      check("slip_locked", 32'(locked), 32'd1);
      check("slip_offset", 32'(offset), 32'd7);
      check("slip_c01", 32'(c), 32'd1);

      // data decode of known bytes, then a C11 token
      enc_cnt = 0;
      enqueue(tmds_encode(8'hFF));
      enqueue(tmds_encode(8'h00));
      enqueue(tmds_encode(8'hAB));
      repeat (6) enqueue(TOKS[3]);
      seen.delete();
      while (txq.size() >= 10) begin
         step(pull(), 1'b0);
         if (de === 1'b1) seen.push_back(data);
      end
      check("data_count", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3; i++) check("data_byte", 32'(seen[i]), 32'(want_bytes[i]));
      check("ctl_c11", 32'(c), 32'd3);
      check("ctl_de0", 32'(de), 32'd0);

      // lock loss by one-bit slip, then relock at the new offset
      void'(txq.pop_front());
      repeat (20) enqueue(TOKS[3]);
      saw_drop = 1'b0;
      while (txq.size() >= 10) begin
         step(pull(), 1'b0);
         if (locked === 1'b0) saw_drop = 1'b1;
      end
      check("lock_lost", 32'(saw_drop), 32'd1);
      check("relock", 32'(locked), 32'd1);
      check("relock_off", 32'(offset), 32'd6);

      // interrupted CHECK: 5 tokens, one data symbol, then fresh tokens
      do_reset(2);
      enc_cnt = 0;
      repeat (5) enqueue(TOKS[2]);
      enqueue(tmds_encode(8'h55));
      repeat (12) enqueue(TOKS[2]);
      for (int i = 1; i <= 18; i++) begin
         step(pull(), 1'b0);
         if (i == 10) check("intr_no_lock", 32'(locked), 32'd0);
         if (i == 15) check("intr_not_yet", 32'(locked), 32'd0);
         if (i == 16) check("intr_lock", 32'(locked), 32'd1);
      end

      // randomized blanking/active traffic with slips and mid-frame resets
      for (int blk = 0; blk < 60; blk++) begin
         int ct;
         ct = $urandom_range(0, 3);
         enc_cnt = 0;
         repeat ($urandom_range(2, 14)) enqueue(TOKS[ct]);
         repeat ($urandom_range(3, 30)) enqueue(tmds_encode(8'($urandom_range(0, 255))));
         if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 9)) void'(txq.pop_front());
         if ($urandom_range(0, 15) == 0) step(10'($urandom), 1'b1);
         drain();
      end
      repeat (12) enqueue(TOKS[0]);
      drain();

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
